// File: rtl/seq_pkg.sv
// ---------------------------------------------------------------------------
// seq_pkg
// Shared types and constants for the fetch/decode/execute/writeback sequencer
// of the 8-bit core.
//   seq_state_t : sequencer FSM state encoding
//   OP_*        : decoder operation codes (OP_ILLEGAL halts the core)
//   OP_W        : width of the operation code presented to the ALU
// ---------------------------------------------------------------------------
package seq_pkg;

   localparam int OP_W = 4;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      FETCH     = 3'd1,
      DECODE    = 3'd2,
      EXECUTE   = 3'd3,
      WRITEBACK = 3'd4,
      HALT      = 3'd5
   } seq_state_t;

   localparam logic [OP_W-1:0] OP_MOVF    = 4'd0;
   localparam logic [OP_W-1:0] OP_MOVWF   = 4'd1;
   localparam logic [OP_W-1:0] OP_ADDWF   = 4'd2;
   localparam logic [OP_W-1:0] OP_SUBWF   = 4'd3;
   localparam logic [OP_W-1:0] OP_ANDWF   = 4'd4;
   localparam logic [OP_W-1:0] OP_INCF    = 4'd5;
   localparam logic [OP_W-1:0] OP_DECF    = 4'd6;
   localparam logic [OP_W-1:0] OP_XORWF   = 4'd7;
   localparam logic [OP_W-1:0] OP_ILLEGAL = 4'd8;
   localparam logic [OP_W-1:0] OP_CLR     = 4'd9;
   localparam logic [OP_W-1:0] OP_IORWF   = 4'd10;
   localparam logic [OP_W-1:0] OP_SWAP    = 4'd11;

endpackage

// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
// Multi-cycle controller for the 8-bit core. Fetches one instruction byte per
// instruction over a req/valid handshake, holds it in the instruction register
// feeding the external decoder, strobes the ALU with the decoded operation and
// then issues the W or F register write. Owns the PC; halts on illegal codes.
//
// Ports:
//   clk, rst            clock (rising edge), async active-high reset
//   run                 level: execute / stop at next instruction boundary
//   pm_req, pm_addr     program memory request and address (= pc)
//   pm_valid, pm_data   program memory response
//   inst_reg            instruction register, drives the decoder
//   inst, d             decoder operation code and destination bit
//   alu_op, alu_go      latched operation code and one-cycle ALU start
//   w_we, f_we          W / file register write enables (one cycle)
//   retired             one-cycle pulse per completed instruction
//   halted              sticky illegal-opcode flag (cleared only by rst)
//   pc                  current program counter
// ---------------------------------------------------------------------------
module fetch_sequencer
   import seq_pkg::*;
#(
   parameter int              PC_W     = 8,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            run,
   output logic            pm_req,
   output logic [PC_W-1:0] pm_addr,
   input  logic            pm_valid,
   input  logic [7:0]      pm_data,
   output logic [7:0]      inst_reg,
   input  logic [OP_W-1:0] inst,
   input  logic            d,
   output logic [OP_W-1:0] alu_op,
   output logic            alu_go,
   output logic            w_we,
   output logic            f_we,
   output logic            retired,
   output logic            halted,
   output logic [PC_W-1:0] pc
);

   seq_state_t      state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [7:0]      inst_reg_q, inst_reg_d;
   logic [OP_W-1:0] alu_op_q, alu_op_d;
   logic            dst_q, dst_d;      // registered copy of d: 1 = F, 0 = W
   logic            pm_req_q, pm_req_d;
   logic            alu_go_q, alu_go_d;
   logic            w_we_q, w_we_d;
   logic            f_we_q, f_we_d;
   logic            retired_q, retired_d;
   logic            halted_q, halted_d;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      inst_reg_d = inst_reg_q;
      alu_op_d   = alu_op_q;
      dst_d      = dst_q;

      case (state_q)
         IDLE: begin
            if (run) state_d = FETCH;
         end
         FETCH: begin
            if (pm_valid) begin
               inst_reg_d = pm_data;
               state_d    = DECODE;
            end
         end
         DECODE: begin
            // Decoder has had a full cycle to settle on inst_reg.
            alu_op_d = inst;
            dst_d    = d;
            if (inst == OP_ILLEGAL || inst_reg_q[7:6] != 2'b00)
               state_d = HALT;
            else
               state_d = EXECUTE;
         end
         EXECUTE: begin
            state_d = WRITEBACK;
         end
         WRITEBACK: begin
            pc_d    = pc_q + 1'b1;   // wraps naturally at 2^PC_W
            state_d = run ? FETCH : IDLE;
         end
         HALT: begin
            state_d = HALT;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Outputs are registered from the next state so each one is a clean
      // flop output that is valid for exactly the cycles spent in that state.
      pm_req_d  = (state_d == FETCH);
      alu_go_d  = (state_d == EXECUTE);
      w_we_d    = (state_d == WRITEBACK) && !dst_d;
      f_we_d    = (state_d == WRITEBACK) &&  dst_d;
      retired_d = (state_d == WRITEBACK);
      halted_d  = (state_d == HALT);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         pc_q       <= RESET_PC;
         inst_reg_q <= '0;
         alu_op_q   <= '0;
         dst_q      <= 1'b0;
         pm_req_q   <= 1'b0;
         alu_go_q   <= 1'b0;
         w_we_q     <= 1'b0;
         f_we_q     <= 1'b0;
         retired_q  <= 1'b0;
         halted_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         inst_reg_q <= inst_reg_d;
         alu_op_q   <= alu_op_d;
         dst_q      <= dst_d;
         pm_req_q   <= pm_req_d;
         alu_go_q   <= alu_go_d;
         w_we_q     <= w_we_d;
         f_we_q     <= f_we_d;
         retired_q  <= retired_d;
         halted_q   <= halted_d;
      end
   end

   assign pm_req   = pm_req_q;
   assign pm_addr  = pc_q;
   assign inst_reg = inst_reg_q;
   assign alu_op   = alu_op_q;
   assign alu_go   = alu_go_q;
   assign w_we     = w_we_q;
   assign f_we     = f_we_q;
   assign retired  = retired_q;
   assign halted   = halted_q;
   assign pc       = pc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fetch_sequencer
// Directed bench for fetch_sequencer. The bench stands in for the decoder by
// driving inst/d directly. A second instance with RESET_PC = 8'hFF shares all
// inputs and is used for the PC wrap case.
// ---------------------------------------------------------------------------
module tb_fetch_sequencer;
   import seq_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       run = 1'b0;
   logic       pm_valid = 1'b0;
   logic [7:0] pm_data = 8'h00;
   logic [3:0] inst = 4'd0;
   logic       d = 1'b0;

   logic       pm_req, alu_go, w_we, f_we, retired, halted;
   logic [7:0] pm_addr, inst_reg, pc;
   logic [3:0] alu_op;

   logic       pm_req2, alu_go2, w_we2, f_we2, retired2, halted2;
   logic [7:0] pm_addr2, inst_reg2, pc2;
   logic [3:0] alu_op2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fetch_sequencer #(.PC_W(8), .RESET_PC(8'h00)) dut (
      .clk(clk), .rst(rst), .run(run),
      .pm_req(pm_req), .pm_addr(pm_addr), .pm_valid(pm_valid), .pm_data(pm_data),
      .inst_reg(inst_reg), .inst(inst), .d(d),
      .alu_op(alu_op), .alu_go(alu_go), .w_we(w_we), .f_we(f_we),
      .retired(retired), .halted(halted), .pc(pc)
   );

   fetch_sequencer #(.PC_W(8), .RESET_PC(8'hFF)) dut_wrap (
      .clk(clk), .rst(rst), .run(run),
      .pm_req(pm_req2), .pm_addr(pm_addr2), .pm_valid(pm_valid), .pm_data(pm_data),
      .inst_reg(inst_reg2), .inst(inst), .d(d),
      .alu_op(alu_op2), .alu_go(alu_go2), .w_we(w_we2), .f_we(f_we2),
      .retired(retired2), .halted(halted2), .pc(pc2)
   );

   // Advance one clock; inputs are changed and outputs sampled 1 ns later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Packed view of the strobe outputs: {pm_req, alu_go, w_we, f_we, retired, halted}
   function automatic logic [5:0] strobes();
      return {pm_req, alu_go, w_we, f_we, retired, halted};
   endfunction

   task automatic do_reset();
      rst = 1'b1; run = 1'b0; pm_valid = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; run = 1'b0;
      #2;
      checks++;
      if (strobes() !== 6'b000000) begin
         errors++; $display("FAIL reset_strobes: got %b exp 000000", strobes());
      end
      checks++;
      if (pc !== 8'h00 || inst_reg !== 8'h00 || alu_op !== 4'd0) begin
         errors++; $display("FAIL reset_regs: pc=%h ir=%h op=%h exp 00 00 0", pc, inst_reg, alu_op);
      end
      tick();
      rst = 1'b0;
      tick();
      checks++;
      if (pm_req !== 1'b0) begin
         errors++; $display("FAIL idle_no_run: pm_req=%b exp 0", pm_req);
      end
   endtask

   // ADDWF d=1, zero-wait memory: FETCH, DECODE, EXECUTE, WRITEBACK.
   task automatic test_zero_wait();
      pm_data = 8'h1E; inst = OP_ADDWF; d = 1'b1; pm_valid = 1'b1; run = 1'b1;
      tick();   // cycle 1: FETCH
      checks++;
      if (pm_req !== 1'b1 || pm_addr !== 8'h00) begin
         errors++; $display("FAIL zw_fetch: req=%b addr=%h exp 1 00", pm_req, pm_addr);
      end
      tick();   // cycle 2: DECODE
      pm_valid = 1'b0;
      checks++;
      if (inst_reg !== 8'h1E || pm_req !== 1'b0 || alu_go !== 1'b0) begin
         errors++; $display("FAIL zw_decode: ir=%h req=%b go=%b exp 1e 0 0", inst_reg, pm_req, alu_go);
      end
      tick();   // cycle 3: EXECUTE
      checks++;
      if (alu_op !== 4'd2 || alu_go !== 1'b1 || w_we !== 1'b0 || f_we !== 1'b0) begin
         errors++; $display("FAIL zw_execute: op=%0d go=%b w=%b f=%b exp 2 1 0 0", alu_op, alu_go, w_we, f_we);
      end
      tick();   // cycle 4: WRITEBACK
      run = 1'b0;
      checks++;
      if (strobes() !== 6'b000110 || pc !== 8'h00) begin
         errors++; $display("FAIL zw_writeback: strobes=%b pc=%h exp 000110 00", strobes(), pc);
      end
      tick();   // back to IDLE
      checks++;
      if (strobes() !== 6'b000000 || pc !== 8'h01) begin
         errors++; $display("FAIL zw_retire: strobes=%b pc=%h exp 000000 01", strobes(), pc);
      end
   endtask

   // ANDWF d=0 with 3 wait cycles: 7 cycles from FETCH to WRITEBACK.
   task automatic test_wait_states();
      pm_data = 8'h14; inst = OP_ANDWF; d = 1'b0; pm_valid = 1'b0; run = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         tick();   // FETCH cycles 1..4
         checks++;
         if (pm_req !== 1'b1 || pm_addr !== 8'h01) begin
            errors++; $display("FAIL ws_fetch_c%0d: req=%b addr=%h exp 1 01", c, pm_req, pm_addr);
         end
      end
      pm_valid = 1'b1;
      tick();   // cycle 5: DECODE
      pm_valid = 1'b0;
      checks++;
      if (pm_req !== 1'b0 || inst_reg !== 8'h14) begin
         errors++; $display("FAIL ws_decode: req=%b ir=%h exp 0 14", pm_req, inst_reg);
      end
      tick();   // cycle 6: EXECUTE
      checks++;
      if (alu_go !== 1'b1 || alu_op !== 4'd4) begin
         errors++; $display("FAIL ws_execute: go=%b op=%0d exp 1 4", alu_go, alu_op);
      end
      tick();   // cycle 7: WRITEBACK
      run = 1'b0;
      checks++;
      if (w_we !== 1'b1 || f_we !== 1'b0 || retired !== 1'b1) begin
         errors++; $display("FAIL ws_writeback: w=%b f=%b ret=%b exp 1 0 1", w_we, f_we, retired);
      end
      tick();
      checks++;
      if (pc !== 8'h02 || pm_req !== 1'b0) begin
         errors++; $display("FAIL ws_retire: pc=%h req=%b exp 02 0", pc, pm_req);
      end
   endtask

   // Top bits 01 halt the core; it stays halted until rst.
   task automatic test_halt();
      pm_data = 8'h40; inst = OP_MOVF; d = 1'b1; pm_valid = 1'b1; run = 1'b1;
      tick();   // FETCH
      tick();   // DECODE
      pm_valid = 1'b0;
      tick();   // HALT
      checks++;
      if (strobes() !== 6'b000001 || pc !== 8'h02) begin
         errors++; $display("FAIL halt_enter: strobes=%b pc=%h exp 000001 02", strobes(), pc);
      end
      for (int c = 0; c < 10; c++) tick();
      checks++;
      if (strobes() !== 6'b000001 || pc !== 8'h02) begin
         errors++; $display("FAIL halt_sticky: strobes=%b pc=%h exp 000001 02", strobes(), pc);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (halted !== 1'b0 || pc !== 8'h00) begin
         errors++; $display("FAIL halt_rst: halted=%b pc=%h exp 0 00", halted, pc);
      end
      run = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   // Legal top bits but decoder reports the illegal code.
   task automatic test_illegal_opcode();
      do_reset();
      pm_data = 8'h20; inst = OP_ILLEGAL; d = 1'b0; pm_valid = 1'b1; run = 1'b1;
      tick();
      tick();
      pm_valid = 1'b0;
      tick();
      checks++;
      if (strobes() !== 6'b000001 || pc !== 8'h00 || alu_op !== 4'd8) begin
         errors++; $display("FAIL illegal_op: strobes=%b pc=%h op=%0d exp 000001 00 8", strobes(), pc, alu_op);
      end
      do_reset();
   endtask

   task automatic test_pc_wrap();
      do_reset();
      checks++;
      if (pc2 !== 8'hFF) begin
         errors++; $display("FAIL wrap_reset_pc: pc=%h exp ff", pc2);
      end
      pm_data = 8'h05; inst = OP_INCF; d = 1'b1; pm_valid = 1'b1; run = 1'b1;
      tick();
      checks++;
      if (pm_addr2 !== 8'hFF) begin
         errors++; $display("FAIL wrap_addr: addr=%h exp ff", pm_addr2);
      end
      tick();
      pm_valid = 1'b0;
      tick();
      tick();   // WRITEBACK
      run = 1'b0;
      tick();
      checks++;
      if (pc2 !== 8'h00 || pc !== 8'h01) begin
         errors++; $display("FAIL wrap_pc: pc2=%h pc=%h exp 00 01", pc2, pc);
      end
   endtask

   // run dropped mid-instruction: instruction completes, then IDLE.
   task automatic test_run_drop();
      do_reset();
      pm_data = 8'h05; inst = OP_MOVF; d = 1'b0; pm_valid = 1'b1; run = 1'b1;
      tick();   // FETCH
      tick();   // DECODE
      pm_valid = 1'b0;
      tick();   // EXECUTE
      run = 1'b0;
      tick();   // WRITEBACK
      checks++;
      if (w_we !== 1'b1 || retired !== 1'b1) begin
         errors++; $display("FAIL drop_writeback: w=%b ret=%b exp 1 1", w_we, retired);
      end
      tick();
      tick();
      checks++;
      if (pm_req !== 1'b0 || pc !== 8'h01 || strobes() !== 6'b000000) begin
         errors++; $display("FAIL drop_idle: req=%b pc=%h strobes=%b exp 0 01 000000", pm_req, pc, strobes());
      end
      run = 1'b1;
      tick();
      checks++;
      if (pm_req !== 1'b1 || pm_addr !== 8'h01) begin
         errors++; $display("FAIL drop_resume: req=%b addr=%h exp 1 01", pm_req, pm_addr);
      end
   endtask

   // Continues from a FETCH at pc=1 with run=1.
   task automatic test_rst_mid_instruction();
      pm_valid = 1'b1; inst = OP_SWAP; d = 1'b1; pm_data = 8'h2D;
      tick();   // DECODE
      pm_valid = 1'b0;
      tick();   // EXECUTE
      tick();   // WRITEBACK
      checks++;
      if (f_we !== 1'b1) begin
         errors++; $display("FAIL rst_wb_pre: f=%b exp 1", f_we);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (strobes() !== 6'b000000 || pc !== 8'h00 || inst_reg !== 8'h00 || alu_op !== 4'd0) begin
         errors++; $display("FAIL rst_in_wb: strobes=%b pc=%h ir=%h op=%0d exp 000000 00 00 0", strobes(), pc, inst_reg, alu_op);
      end
      run = 1'b0;
      tick();
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
         checks++;
         if (strobes() !== 6'b000000) begin
            errors++; $display("FAIL rst_release_c%0d: strobes=%b exp 000000", c, strobes());
         end
      end
      // Reset while FETCH waits for memory.
      run = 1'b1;
      tick();
      tick();
      checks++;
      if (pm_req !== 1'b1) begin
         errors++; $display("FAIL rst_fetch_pre: req=%b exp 1", pm_req);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (strobes() !== 6'b000000 || pc !== 8'h00) begin
         errors++; $display("FAIL rst_in_fetch: strobes=%b pc=%h exp 000000 00", strobes(), pc);
      end
      run = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      tick();
      checks++;
      if (strobes() !== 6'b000000) begin
         errors++; $display("FAIL rst_fetch_release: strobes=%b exp 000000", strobes());
      end
   endtask

   initial begin
      test_reset();
      test_zero_wait();
      test_wait_states();
      test_halt();
      test_illegal_opcode();
      test_pc_wrap();
      test_run_drop();
      test_rst_mid_instruction();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Multi-cycle fetch/decode/execute/writeback controller for the 8-bit core. Fetches one instruction byte per instruction from program memory over a req/valid handshake and holds it in the instruction register that feeds the instruction decoder. Sequences the ALU with the decoder's 4-bit operation code and `d` bit, then issues the W or F register write. Owns the program counter and halts on illegal opcodes.

## Interface
- `PC_W`, 8, program counter / program memory address width
- `RESET_PC`, 0, PC value loaded at reset
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `run`  in  1  level; 1 = execute instructions, 0 = stop at next instruction boundary
- `pm_req`  out  1  program memory fetch request
- `pm_addr`  out  PC_W  fetch address (= PC)
- `pm_valid`  in  1  fetch data valid
- `pm_data`  in  8  fetched instruction byte
- `inst_reg`  out  8  instruction register, drives the decoder
- `inst`  in  4  decoder operation code
- `d`  in  1  decoder destination bit (0 = W, 1 = F)
- `alu_op`  out  4  operation code presented to ALU
- `alu_go`  out  1  one-cycle ALU start strobe
- `w_we`  out  1  W register write enable
- `f_we`  out  1  file register write enable
- `retired`  out  1  one-cycle pulse per completed instruction
- `halted`  out  1  sticky illegal-opcode flag
- `pc`  out  PC_W  current program counter

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALT.
- IDLE: outputs inactive; `run`=1 → FETCH.
- FETCH: `pm_req`=1, `pm_addr`=`pc`. On a cycle with `pm_valid`=1, `inst_reg`<=`pm_data`, → DECODE. `pm_valid` is ignored outside FETCH.
- DECODE: single cycle for the decoder to settle. Latch `alu_op`<=`inst` and a registered destination copy of `d`. If `inst`==8 (illegal) or `inst_reg[7:6]`!=2'b00 → HALT. Otherwise → EXECUTE.
- EXECUTE: `alu_go`=1 for exactly this cycle → WRITEBACK.
- WRITEBACK: `f_we`=1 if latched d=1, otherwise `w_we`=1, for exactly this cycle. `pc`<=`pc`+1, wrapping modulo 2^PC_W. `retired`=1. Then → FETCH if `run`=1, else → IDLE.
- HALT: `halted`=1 and all strobes 0. Exits only via `rst`. `pc` holds the address of the offending instruction.
- Opcode values: 0 MOVF, 1 MOVWF, 2 ADDWF, 3 SUBWF, 4 ANDWF, 5 INCF, 6 DECF, 7 XORWF, 8 ILLEGAL, 9 CLR, 10 IORWF, 11 SWAP. All non-illegal codes are treated identically by the sequencer. Destination is selected only by `d`.
- `run` is sampled only in IDLE and at the end of WRITEBACK. A deassertion mid-instruction completes that instruction.

## Timing
- Reset values: state IDLE, `pc`=RESET_PC, `inst_reg`=0, `alu_op`=0, and `pm_req`, `alu_go`, `w_we`, `f_we`, `retired`, `halted` all 0.
- Zero-wait memory (`pm_valid` in the first FETCH cycle) gives 4 cycles per instruction: FETCH, DECODE, EXECUTE, WRITEBACK. Each wait cycle adds 1.
- `pm_req` stays high and `pm_addr` stays stable until `pm_valid` is seen. `pm_req` drops in the cycle after the valid.
- All outputs are registered or decoded from state only. No combinational path from inputs to outputs.
- `rst` asserted in any state returns everything to reset values immediately. An in-flight fetch is abandoned, and no partial write strobe is allowed.
- PC wrap: with `pc`=2^PC_W-1, WRITEBACK yields `pc`=0.

## Structure
- Package `seq_pkg`: state enum (`seq_state_t`), opcode localparams (`OP_MOVF` … `OP_SWAP`, `OP_ILLEGAL`=4'd8), and the 4'd width for `alu_op`.
- Single module. The decoder is instantiated alongside it at core level, not inside it. PC increment is inline; no sub-module is needed.

## Test plan
- Reset then `run`=1 with zero-wait memory, `pm_data`=8'h1E (ADDWF, d=1) → `alu_op`=2; `alu_go` in cycle 3 and `f_we` in cycle 4; `retired` pulse; `pc` 0→1.
- Fetch with 3 wait cycles on 8'h14 (ANDWF, d=0) → `pm_req` high for 4 cycles with `pm_addr` stable; then `w_we`=1 and `f_we`=0; 7 cycles total.
- `pm_data`=8'h40 (top bits 01) → HALT; `halted`=1; no `alu_go`, `w_we` or `f_we`; `pc` unchanged; still halted 10 cycles later; `rst` clears it.
- `RESET_PC`=8'hFF, execute one instruction → `pc`=8'h00 after WRITEBACK.
- Drop `run` during EXECUTE → WRITEBACK still completes, then IDLE with `pm_req`=0. Reassert `run` → fetch resumes at the incremented `pc`.
- Assert `rst` during WRITEBACK and during a FETCH wait → all outputs at reset values that cycle; no strobes after release until `run`.
